fetch_frontend: RTL and testbench
=================================

FETCH_FRONTEND -- requirements
Module: fetch_frontend

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL have port PHI0  input  1  single core clock; all state updates on its rising edge.
REQ-003 SHALL have port RES  input  1  synchronous active-high reset.
REQ-004 SHALL have port DATA  input  8  internal data bus value, valid every cycle.
REQ-005 SHALL have port n_ready  input  1  1 = processor stalled (RDY low); all state held.
REQ-006 SHALL have port FETCH  input  1  opcode-fetch strobe from the dispatcher.
REQ-007 SHALL have port Z_IR  input  1  1 during FETCH = inject BRK (0x00) into IR.
REQ-008 SHALL have port T1  input  1  dispatcher T1 timing state.
REQ-009 SHALL have port TRES2  input  1  dispatcher reset of extended timing states.
REQ-010 SHALL have port PD  output  8  predecode register contents.
REQ-011 SHALL have port IR  output  8  instruction register.
REQ-012 SHALL have port n_IMPLIED  output  1  0 = PD holds an implied/accumulator opcode.
REQ-013 SHALL have port n_TWOCYCLE  output  1  0 = PD holds a two-cycle opcode.
REQ-014 SHALL have port T2, T3, T4, T5  output  1 each  extended cycle states, at most one high.

Function
REQ-015 SHALL load PD <= DATA on each edge with n_ready=0; hold PD when n_ready=1.
REQ-016 SHALL decode IMPLIED = PD[3] & ~PD[2] & ~PD[0] (pattern xxxx10x0); n_IMPLIED = ~IMPLIED; combinational from PD, zero latency.
REQ-017 SHALL decode IMM = (PD[4:2]=010 & PD[0]=1) | (PD[7]=1 & PD[4:2]=000 & PD[0]=0).
REQ-018 SHALL decode PUSHPULL = IMPLIED & ~PD[7] & ~PD[4] & ~PD[1] (0x08/0x28/0x48/0x68).
REQ-019 SHALL drive n_TWOCYCLE = ~(IMM | (IMPLIED & ~PUSHPULL)).
REQ-020 SHALL load IR <= PD on an edge with FETCH=1, n_ready=0 and Z_IR=0.
REQ-021 SHALL load IR <= 0x00 on an edge with FETCH=1, n_ready=0 and Z_IR=1, irrespective of PD.
REQ-022 SHALL hold IR when FETCH=0 or n_ready=1, including when FETCH=1 during a stall.
REQ-023 SHALL, on an edge with n_ready=0 and TRES2=0, shift T2<=T1, T3<=T2, T4<=T3, T5<=T4; T5 shifts out and is lost.
REQ-024 SHALL, on an edge with n_ready=0 and TRES2=1, clear T2..T5 (TRES2 wins over the shift).
REQ-025 SHALL hold T2..T5 when n_ready=1, regardless of TRES2 and T1.
REQ-026 SHALL, when FETCH and a T-shift occur on the same edge, perform both updates independently.

Reset
REQ-027 SHALL, on an edge with RES=1, set PD=0x00, IR=0x00 (BRK) and T2..T5=0; RES overrides n_ready, FETCH and TRES2.
REQ-028 SHALL drive n_IMPLIED=1 and n_TWOCYCLE=1 while PD=0x00, including the first cycle after reset.
REQ-029 SHALL resume normal loading on the first edge with RES=0; reset asserted mid-instruction discards IR and timing state.

Structure
REQ-030 SHALL place the BRK opcode constant (8'h00), the IMM/IMPLIED/PUSHPULL bit patterns and the T-state count (4) in the shared core package.
REQ-031 SHALL implement the REQ-016..019 decode as one combinational sub-module, predecode_logic (in PD[7:0], out n_IMPLIED, n_TWOCYCLE).
REQ-032 SHALL contain no latches; all state is in flip-flops on the PHI0 rising edge.

Verification
REQ-033 SHALL verify that DATA=0xA9, n_ready=0 for one edge gives PD=0xA9, n_TWOCYCLE=0, n_IMPLIED=1; DATA=0x48 gives n_IMPLIED=0, n_TWOCYCLE=1; DATA=0xEA gives both 0.
REQ-034 SHALL verify that PD=0x6D with FETCH=1, Z_IR=0 gives IR=0x6D after the edge; the same with Z_IR=1 gives IR=0x00.
REQ-035 SHALL verify that T1 pulsed for one cycle with TRES2=0 moves a single high bit through T2, T3, T4, T5 on four successive edges, then all bits return to 0.
REQ-036 SHALL verify that, with T3=1, raising n_ready=1 for 3 cycles holds T3=1 and holds PD and IR unchanged while DATA toggles; on release, T4=1 after the next edge.
REQ-037 SHALL verify that, with T4=1, asserting TRES2=1 and T1=1 on the same edge gives T2..T5=0.
REQ-038 SHALL verify that RES=1 with n_ready=1, FETCH=1 and PD=0xA9 gives PD=0x00, IR=0x00, T2..T5=0, n_TWOCYCLE=1 and n_IMPLIED=1 after one edge.

Source files
------------

// File: rtl/fetch_frontend_pkg.sv
// Shared core package for the fetch front end: opcode constants, predecode
// bit patterns (mask/value pairs) and the number of extended timing states.
package fetch_frontend_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned T_STATE_COUNT = 4;

  localparam logic [DATA_W-1:0] BRK_OPCODE = 8'h00;

  // IMPLIED: xxxx10x0
  localparam logic [DATA_W-1:0] IMPLIED_MASK  = 8'b0000_1101;
  localparam logic [DATA_W-1:0] IMPLIED_VALUE = 8'b0000_1000;

  // IMM, first form: xxx010x1
  localparam logic [DATA_W-1:0] IMM_A_MASK  = 8'b0001_1101;
  localparam logic [DATA_W-1:0] IMM_A_VALUE = 8'b0000_1001;

  // IMM, second form: 1xx000x0
  localparam logic [DATA_W-1:0] IMM_B_MASK  = 8'b1001_1101;
  localparam logic [DATA_W-1:0] IMM_B_VALUE = 8'b1000_0000;

  // PUSHPULL: IMPLIED with bits 7, 4 and 1 clear (0x08/0x28/0x48/0x68)
  localparam logic [DATA_W-1:0] PUSHPULL_MASK  = 8'b1001_1111;
  localparam logic [DATA_W-1:0] PUSHPULL_VALUE = 8'b0000_1000;

  // True when the masked bits of pd equal value.
  function automatic logic pd_match(input logic [DATA_W-1:0] pd,
                                    input logic [DATA_W-1:0] mask,
                                    input logic [DATA_W-1:0] value);
    return (pd & mask) == value;
  endfunction

endpackage

// File: rtl/fetch_frontend_predecode.sv
// predecode_logic: purely combinational decode of the predecode register.
// Ports:
//   PD         - predecode register contents
//   n_IMPLIED  - 0 when PD holds an implied/accumulator opcode
//   n_TWOCYCLE - 0 when PD holds a two-cycle opcode (immediate, or implied
//                that is not a push/pull)
module predecode_logic
  import fetch_frontend_pkg::*;
(
  input  logic [DATA_W-1:0] PD,
  output logic              n_IMPLIED,
  output logic              n_TWOCYCLE
);

  logic implied;
  logic imm;
  logic pushpull;

  // Pattern matches against the package constants.
  always_comb begin
    implied  = pd_match(PD, IMPLIED_MASK, IMPLIED_VALUE);
    imm      = pd_match(PD, IMM_A_MASK, IMM_A_VALUE)
             | pd_match(PD, IMM_B_MASK, IMM_B_VALUE);
    pushpull = pd_match(PD, PUSHPULL_MASK, PUSHPULL_VALUE);
  end

  assign n_IMPLIED  = ~implied;
  assign n_TWOCYCLE = ~(imm | (implied & ~pushpull));

endmodule

// File: rtl/fetch_frontend.sv
// fetch_frontend: predecode register, instruction register and extended
// timing-state shifter of the opcode fetch path.
// Ports:
//   PHI0       - core clock, rising edge
//   RES        - synchronous active-high reset (overrides everything)
//   DATA       - internal data bus
//   n_ready    - 1 = stall, all state held
//   FETCH      - opcode fetch strobe; Z_IR forces BRK into IR
//   T1, TRES2  - dispatcher timing input and clear of T2..T5
//   PD, IR     - predecode and instruction registers
//   n_IMPLIED, n_TWOCYCLE - combinational predecode of PD
//   T2..T5     - extended timing states (one-hot shift of T1)
module fetch_frontend
  import fetch_frontend_pkg::*;
(
  input  logic              PHI0,
  input  logic              RES,
  input  logic [DATA_W-1:0] DATA,
  input  logic              n_ready,
  input  logic              FETCH,
  input  logic              Z_IR,
  input  logic              T1,
  input  logic              TRES2,
  output logic [DATA_W-1:0] PD,
  output logic [DATA_W-1:0] IR,
  output logic              n_IMPLIED,
  output logic              n_TWOCYCLE,
  output logic              T2,
  output logic              T3,
  output logic              T4,
  output logic              T5
);

  // t_q[0] = T2 ... t_q[3] = T5
  logic [T_STATE_COUNT-1:0] t_q;

  // Predecode register follows the bus whenever the core is not stalled.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      PD <= BRK_OPCODE;
    end else if (!n_ready) begin
      PD <= DATA;
    end
  end

  // Instruction register: latch PD, or inject BRK, on an unstalled fetch.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      IR <= BRK_OPCODE;
    end else if (!n_ready && FETCH) begin
      IR <= Z_IR ? BRK_OPCODE : PD;
    end
  end

  // Timing shifter: TRES2 clears, otherwise T1 enters at T2 and T5 drops off.
  always_ff @(posedge PHI0) begin
    if (RES) begin
      t_q <= '0;
    end else if (!n_ready) begin
      if (TRES2) begin
        t_q <= '0;
      end else begin
        t_q <= {t_q[T_STATE_COUNT-2:0], T1};
      end
    end
  end

  assign T2 = t_q[0];
  assign T3 = t_q[1];
  assign T4 = t_q[2];
  assign T5 = t_q[3];

  predecode_logic u_predecode (
    .PD        (PD),
    .n_IMPLIED (n_IMPLIED),
    .n_TWOCYCLE(n_TWOCYCLE)
  );

endmodule

// File: tb/tb_fetch_frontend.sv
// Directed, table-driven bench for fetch_frontend.
module tb_fetch_frontend;

  logic       PHI0 = 1'b0;
  logic       RES, n_ready, FETCH, Z_IR, T1, TRES2;
  logic [7:0] DATA;
  logic [7:0] PD, IR;
  logic       n_IMPLIED, n_TWOCYCLE;
  logic       T2, T3, T4, T5;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 PHI0 = ~PHI0;

  fetch_frontend dut (
    .PHI0      (PHI0),
    .RES       (RES),
    .DATA      (DATA),
    .n_ready   (n_ready),
    .FETCH     (FETCH),
    .Z_IR      (Z_IR),
    .T1        (T1),
    .TRES2     (TRES2),
    .PD        (PD),
    .IR        (IR),
    .n_IMPLIED (n_IMPLIED),
    .n_TWOCYCLE(n_TWOCYCLE),
    .T2        (T2),
    .T3        (T3),
    .T4        (T4),
    .T5        (T5)
  );

  // Inputs applied before an edge and the state expected after it.
  // exp_t is {T5,T4,T3,T2}.
  typedef struct packed {
    logic       res;
    logic       nr;
    logic       fetch;
    logic       zir;
    logic       t1;
    logic       tres2;
    logic [7:0] data;
    logic [7:0] exp_pd;
    logic [7:0] exp_ir;
    logic [3:0] exp_t;
    logic       exp_ni;
    logic       exp_nt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic res, input logic nr,
                               input logic fetch, input logic zir,
                               input logic t1, input logic tres2,
                               input logic [7:0] data,
                               input logic [7:0] exp_pd,
                               input logic [7:0] exp_ir,
                               input logic [3:0] exp_t,
                               input logic exp_ni, input logic exp_nt);
    vec_t v;
    v.res = res; v.nr = nr; v.fetch = fetch; v.zir = zir;
    v.t1 = t1; v.tres2 = tres2; v.data = data;
    v.exp_pd = exp_pd; v.exp_ir = exp_ir; v.exp_t = exp_t;
    v.exp_ni = exp_ni; v.exp_nt = exp_nt;
    return v;
  endfunction

  task automatic drive(input logic res, input logic nr, input logic fetch,
                       input logic zir, input logic t1, input logic tres2,
                       input logic [7:0] data);
    RES = res; n_ready = nr; FETCH = fetch; Z_IR = zir;
    T1 = t1; TRES2 = tres2; DATA = data;
  endtask

  task automatic cmp8(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] exp_pd,
                           input logic [7:0] exp_ir, input logic [3:0] exp_t,
                           input logic exp_ni, input logic exp_nt);
    cmp8({tag, ".PD"}, PD, exp_pd);
    cmp8({tag, ".IR"}, IR, exp_ir);
    cmp8({tag, ".T5T4T3T2"}, {4'h0, T5, T4, T3, T2}, {4'h0, exp_t});
    cmp8({tag, ".n_IMPLIED"}, {7'h0, n_IMPLIED}, {7'h0, exp_ni});
    cmp8({tag, ".n_TWOCYCLE"}, {7'h0, n_TWOCYCLE}, {7'h0, exp_nt});
  endtask

  task automatic edge_wait();
    @(posedge PHI0);
    #1;
  endtask

  initial begin
    //                 res nr fe zi t1 tr data    pd     ir     T5..T2   ni nt
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 8'h55, 8'h00, 8'h00, 4'b0000, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'hA9, 8'hA9, 8'h00, 4'b0000, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h48, 8'h48, 8'h00, 4'b0000, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'hEA, 8'hEA, 8'h00, 4'b0000, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h6D, 8'h6D, 8'h00, 4'b0000, 1, 1));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'h6D, 8'h6D, 8'h6D, 4'b0000, 1, 1));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 0, 8'h6D, 8'h6D, 8'h00, 4'b0000, 1, 1));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 8'h6D, 8'h6D, 8'h6D, 4'b0000, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 8'h6D, 8'h6D, 8'h6D, 4'b0001, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h6D, 8'h6D, 8'h6D, 4'b0010, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h6D, 8'h6D, 8'h6D, 4'b0100, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h6D, 8'h6D, 8'h6D, 4'b1000, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h6D, 8'h6D, 8'h6D, 4'b0000, 1, 1));
    // fetch and shift on the same edge; 0x18 is implied, not push/pull
    vecs.push_back(mkv(0, 0, 1, 0, 1, 0, 8'h18, 8'h18, 8'h6D, 4'b0001, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h6D, 4'b0010, 1, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h6D, 4'b0100, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].res, vecs[i].nr, vecs[i].fetch, vecs[i].zir,
            vecs[i].t1, vecs[i].tres2, vecs[i].data);
      edge_wait();
      check_all($sformatf("vec%0d", i), vecs[i].exp_pd, vecs[i].exp_ir,
                vecs[i].exp_t, vecs[i].exp_ni, vecs[i].exp_nt);
    end

    // Stall with T3 high: DATA toggles, FETCH/T1/TRES2 active, nothing moves.
    drive(0, 1, 1, 0, 1, 0, 8'hFF);
    edge_wait();
    check_all("stall0", 8'h00, 8'h6D, 4'b0100, 1, 1);
    drive(0, 1, 1, 1, 0, 1, 8'h0F);
    edge_wait();
    check_all("stall1", 8'h00, 8'h6D, 4'b0100, 1, 1);
    drive(0, 1, 1, 0, 1, 0, 8'hA9);
    edge_wait();
    check_all("stall2", 8'h00, 8'h6D, 4'b0100, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    edge_wait();
    check_all("release", 8'h00, 8'h6D, 4'b1000, 1, 1);

    // TRES2 wins over T1 with T4 high.
    drive(0, 0, 0, 0, 1, 1, 8'h48);
    edge_wait();
    check_all("tres2", 8'h48, 8'h6D, 4'b0000, 0, 1);

    // Reset overrides stall and fetch with PD=0xA9 and T2 high.
    drive(0, 0, 0, 0, 1, 0, 8'hA9);
    edge_wait();
    check_all("prereset", 8'hA9, 8'h6D, 4'b0001, 1, 0);
    drive(1, 1, 1, 0, 1, 0, 8'h48);
    edge_wait();
    check_all("reset", 8'h00, 8'h00, 4'b0000, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 8'h48);
    edge_wait();
    check_all("resume", 8'h48, 8'h00, 4'b0000, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
